// File: rtl/sig_pulse_counter.sv
// sig_pulse_counter: synchronises `signal`/`button`, debounces the run switch,
// counts `signal` rising edges as 8-digit BCD while running, with overflow.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   button      raw run switch (high = run, low = hold), async
//   signal      raw pulse input, each rising edge one event, async
//   bcd[31:0]   count, digit 0 in [3:0] ... digit 7 in [31:28]
//   running     registered, high while the FSM is in COUNT
//   overflow    sticky, set on 99999999 -> 0 wrap, cleared on COUNT entry
//   pulse_tick  one-cycle registered strobe per counted edge
//
// Build option: define SIG_CNT_DEBOUNCE_EN to include the DEB_CYCLES
// debounce counter; otherwise the debounced button is btn_s plus one flop.
module sig_pulse_counter #(
  parameter int DEB_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic        signal,
  output logic [31:0] bcd,
  output logic        running,
  output logic        overflow,
  output logic        pulse_tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Two-flop synchronisers plus the edge-detect delay flop.
  logic r_sig_m;
  logic r_sig_s;
  logic r_sig_d;
  logic r_btn_m;
  logic r_btn_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig_m <= 1'b0;
      r_sig_s <= 1'b0;
      r_sig_d <= 1'b0;
      r_btn_m <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sig_m <= signal;
      r_sig_s <= r_sig_m;
      r_sig_d <= r_sig_s;
      r_btn_m <= button;
      r_btn_s <= r_btn_m;
    end
  end

  logic w_sig_rise;
  assign w_sig_rise = r_sig_s & ~r_sig_d;

  // Debounced button; w_btn_db_nxt is the value it takes on this edge,
  // so the FSM reacts on the same edge the debounced level changes.
  logic r_btn_db;
  logic w_btn_db_nxt;

`ifdef SIG_CNT_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] r_deb_cnt;
  logic          w_differ;
  logic          w_deb_done;

  assign w_differ   = (r_btn_s != r_btn_db);
  assign w_deb_done = w_differ && (r_deb_cnt == DEB_LAST);
  assign w_btn_db_nxt = w_deb_done ? r_btn_s : r_btn_db;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt <= '0;
    end else if (!w_differ || w_deb_done) begin
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end
`else
  logic w_unused_deb;
  assign w_unused_deb = ^DEB_CYCLES;
  assign w_btn_db_nxt = r_btn_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_db <= 1'b0;
    end else begin
      r_btn_db <= w_btn_db_nxt;
    end
  end

  logic w_db_rise;
  logic w_db_fall;
  assign w_db_rise = w_btn_db_nxt & ~r_btn_db;
  assign w_db_fall = ~w_btn_db_nxt & r_btn_db;

  // FSM
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_db_rise) w_state_nxt = S_COUNT;
      S_HOLD:  if (w_db_rise) w_state_nxt = S_COUNT;
      S_COUNT: if (w_db_fall) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic w_in_count;
  logic w_enter;
  logic w_inc;
  assign w_in_count = (r_state == S_COUNT);
  assign w_enter    = (w_state_nxt == S_COUNT) && !w_in_count;
  // Edges are counted off the current state, so an edge coinciding
  // with leaving COUNT is still counted.
  assign w_inc      = w_in_count && w_sig_rise;

  // BCD incrementer: digit i steps when every lower digit is 9.
  logic [31:0] r_bcd;
  logic [31:0] w_bcd_inc;
  logic [8:0]  w_all9;
  logic        w_wrap;

  assign w_all9[0] = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_dig
    logic [3:0] w_dig;
    logic       w_is9;
    assign w_dig = r_bcd[4*i +: 4];
    assign w_is9 = (w_dig == 4'd9);
    assign w_all9[i+1] = w_all9[i] & w_is9;
    assign w_bcd_inc[4*i +: 4] = !w_all9[i] ? w_dig :
                                 w_is9      ? 4'd0  :
                                              w_dig + 4'd1;
  end

  assign w_wrap = w_all9[8];

  logic r_ovf;
  logic r_tick;
  logic r_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= (w_state_nxt == S_COUNT);
      r_tick  <= w_inc;
    end
  end

  // Count register only written on entry or increment, so it holds
  // its value in HOLD and between edges in COUNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (w_enter) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (w_inc) begin
      r_bcd <= w_bcd_inc;
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bcd        = r_bcd;
  assign running    = r_run;
  assign overflow   = r_ovf;
  assign pulse_tick = r_tick;

endmodule

// File: tb/tb_sig_pulse_counter.sv
// tb_sig_pulse_counter: directed bench for sig_pulse_counter.
// Works with SIG_CNT_DEBOUNCE_EN defined or undefined.
module tb_sig_pulse_counter;

  localparam int DEB = 20;
`ifdef SIG_CNT_DEBOUNCE_EN
  localparam int LAT = DEB + 2;
  localparam logic GLITCH_RUNS = 1'b0;
`else
  localparam int LAT = 3;
  localparam logic GLITCH_RUNS = 1'b1;
`endif

  logic        clk;
  logic        rst;
  logic        button;
  logic        signal;
  logic [31:0] bcd;
  logic        running;
  logic        overflow;
  logic        pulse_tick;

  sig_pulse_counter #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .signal    (signal),
    .bcd       (bcd),
    .running   (running),
    .overflow  (overflow),
    .pulse_tick(pulse_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int n_ticks;

  initial n_ticks = 0;
  always @(negedge clk) if (pulse_tick) n_ticks++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_ne(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    signal = 1'b1;
    wait_ne(2);
    signal = 1'b0;
    wait_ne(2);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  // Called right after button rises (or reset releases with button high).
  task automatic expect_start(input string tag);
    wait_ne(LAT - 1);
    chk({tag, "_early"}, 32'(running), 32'd0);
    wait_ne(1);
    chk({tag, "_run"}, 32'(running), 32'd1);
    chk({tag, "_clr"}, bcd, 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

  int   t0;
  logic seen;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    button = 1'b1;
    signal = 1'b0;

    // Reset held with inputs active
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 signal = ~signal;
      chk("rst_hold", {bcd[28:0], running, overflow, pulse_tick}, 32'h0);
    end
    signal = 1'b0;
    wait_ne(2);
    chk("rst_clk", {bcd[28:0], running, overflow, pulse_tick}, 32'h0);
    chk("rst_bcd", bcd, 32'h0);

    // Release with button high: start after sync + debounce
    rst = 1'b1;
    expect_start("start1");

    // One pulse with exact latency
    signal = 1'b1;
    wait_ne(2);
    chk("lat_n1_bcd", bcd, 32'h0);
    chk("lat_n1_tick", 32'(pulse_tick), 32'd0);
    wait_ne(1);
    chk("lat_n2_bcd", bcd, 32'h1);
    chk("lat_n2_tick", 32'(pulse_tick), 32'd1);
    signal = 1'b0;
    wait_ne(1);
    chk("lat_n3_tick", 32'(pulse_tick), 32'd0);
    wait_ne(1);

    t0 = n_ticks;
    pulses(4);
    chk("basic_bcd", bcd, 32'h5);
    chk("basic_ticks", 32'(n_ticks - t0 + 1), 32'd5);

    // Hold
    button = 1'b0;
    wait_ne(LAT + 1);
    chk("hold_run", 32'(running), 32'd0);
    t0 = n_ticks;
    pulses(3);
    chk("hold_bcd", bcd, 32'h5);
    chk("hold_ticks", 32'(n_ticks - t0), 32'd0);
    chk("hold_run2", 32'(running), 32'd0);

    // Restart clears, then count 2
    button = 1'b1;
    expect_start("restart");
    pulses(2);
    chk("restart_bcd", bcd, 32'h2);

    // Back to HOLD, then a short button glitch
    button = 1'b0;
    wait_ne(LAT + 2);
    chk("glitch_pre", 32'(running), 32'd0);
    seen = 1'b0;
    button = 1'b1;
    for (int i = 0; i < DEB - 1; i++) begin
      @(negedge clk);
      seen |= running;
    end
    button = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      seen |= running;
    end
    chk("glitch_run", 32'(seen), 32'(GLITCH_RUNS));
    chk("glitch_end", 32'(running), 32'd0);

    // Carry chain
    button = 1'b1;
    expect_start("carry_start");
    t0 = n_ticks;
    pulses(9999);
    chk("carry_9999", bcd, 32'h0000_9999);
    chk("carry_ticks", 32'(n_ticks - t0), 32'd9999);
    pulse();
    chk("carry_10000", bcd, 32'h0001_0000);
    chk("carry_ovf", 32'(overflow), 32'd0);

    // Wrap via forced preload while idle in COUNT
    force dut.r_bcd = 32'h9999_9998;
    wait_ne(1);
    release dut.r_bcd;
    wait_ne(1);
    chk("preload", bcd, 32'h9999_9998);
    pulse();
    chk("wrap_m1", bcd, 32'h9999_9999);
    chk("wrap_m1_ovf", 32'(overflow), 32'd0);
    pulse();
    chk("wrap_bcd", bcd, 32'h0);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    pulses(3);
    chk("wrap_post", bcd, 32'h3);
    chk("wrap_sticky", 32'(overflow), 32'd1);

    button = 1'b0;
    wait_ne(LAT + 1);
    chk("ovf_hold", 32'(overflow), 32'd1);
    chk("ovf_hold_bcd", bcd, 32'h3);
    button = 1'b1;
    expect_start("ovf_restart");
    pulses(2);
    chk("pre_rst_bcd", bcd, 32'h2);

    // Async reset between edges
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_bcd", bcd, 32'h0);
    chk("async_flags", {29'd0, running, overflow, pulse_tick}, 32'h0);
    wait_ne(2);
    rst = 1'b1;
    expect_start("post_rst");
    pulses(1);
    chk("post_rst_cnt", bcd, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
